// File: rtl/chacha_ctrl_pkg.sv
// Shared types and constants for the ChaCha20 multi-block session controller.
// Field widths, field codes, FSM states and words-per-field helpers.
package chacha_ctrl_pkg;

  localparam int KEY_W   = 256;
  localparam int NONCE_W = 96;
  localparam int CTR_W   = 32;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    FIELD_KEY   = 2'd0,
    FIELD_NONCE = 2'd1,
    FIELD_CTR   = 2'd2
  } field_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACQ_KEY   = 3'd1,
    ST_ACQ_NONCE = 3'd2,
    ST_ACQ_CTR   = 3'd3,
    ST_CORE_GO   = 3'd4,
    ST_CORE_WAIT = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  function automatic int field_bits(input field_t f);
    int bits;
    unique case (f)
      FIELD_KEY:   bits = KEY_W;
      FIELD_NONCE: bits = NONCE_W;
      default:     bits = CTR_W;
    endcase
    return bits;
  endfunction

  function automatic int words_per_field(input field_t f, input int chunk_w);
    return field_bits(f) / chunk_w;
  endfunction

  function automatic logic [IDX_W-1:0] last_index(input field_t f, input int chunk_w);
    return IDX_W'(words_per_field(f, chunk_w) - 1);
  endfunction

endpackage

// File: rtl/chacha_field_assembler.sv
// Word acquisition front end: stream/TRNG source mux, word index counter,
// accept decode and stream stall timeout for the field currently being loaded.
module chacha_field_assembler
  import chacha_ctrl_pkg::*;
#(
  parameter int CHUNK_W = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic               use_stream,
  input  field_t             field,
  input  logic               chunk_valid,
  input  logic [1:0]         chunk_type,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic               trng_ready,
  input  logic [31:0]        trng_data,
  output logic               chunk_request,
  output logic               trng_request,
  output logic [1:0]         request_type,
  output logic [IDX_W-1:0]   chunk_index,
  output logic               accept,
  output logic               last,
  output logic               timeout,
  output logic [CHUNK_W-1:0] word
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [IDX_W-1:0] idx_q;
  logic [TW-1:0]    tcnt_q;
  logic             stall;

  assign chunk_request = active & use_stream;
  assign trng_request  = active & ~use_stream;
  assign request_type  = active ? 2'(field) : 2'(FIELD_KEY);
  assign chunk_index   = idx_q;

  // A stream word tagged for another field is simply not accepted.
  assign accept = chunk_request ? (chunk_valid && (chunk_type == 2'(field)))
                                : (trng_request && trng_ready);
  assign last   = accept && (idx_q == last_index(field, CHUNK_W));
  assign word   = use_stream ? chunk : trng_data[CHUNK_W-1:0];
  assign stall  = chunk_request && !accept;

  if (CHUNK_W < 32) begin : g_trng_pad
    logic unused_trng_hi;
    assign unused_trng_hi = ^trng_data[31:CHUNK_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (!active) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

  // Counts consecutive stalled cycles; the abort fires on the cycle the count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (!stall) begin
      tcnt_q <= '0;
    end else if (TIMEOUT != 0) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign timeout = (TIMEOUT != 0) && stall && (32'(tcnt_q) == 32'(TIMEOUT - 1));

endmodule

// File: rtl/chacha_multiblock_ctrl.sv
// ChaCha20 session controller: loads key/nonce/counter from stream or TRNG, then runs
// 1..MAX_BLOCKS core blocks. Optional key cache enabled by defining CHACHA_KEY_CACHE_EN.
module chacha_multiblock_ctrl
  import chacha_ctrl_pkg::*;
#(
  parameter  int CHUNK_W    = 32,
  parameter  int MAX_BLOCKS = 16,
  parameter  int TIMEOUT    = 1024,
  localparam int BLK_W      = $clog2(MAX_BLOCKS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BLK_W-1:0]   num_blocks,
  input  logic               use_streamed_key,
  input  logic               use_streamed_nonce,
  input  logic               use_streamed_counter,
`ifdef CHACHA_KEY_CACHE_EN
  input  logic               reuse_key,
`endif
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               chunk_request,
  output logic [1:0]         request_type,
  output logic [IDX_W-1:0]   chunk_index,
  input  logic               chunk_valid,
  input  logic [1:0]         chunk_type,
  input  logic [CHUNK_W-1:0] chunk,
  output logic               trng_request,
  input  logic               trng_ready,
  input  logic [31:0]        trng_data,
  output logic               core_start,
  input  logic               core_done,
  output logic [KEY_W-1:0]   core_key,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [CTR_W-1:0]   core_counter,
  output logic               block_valid,
  output logic [BLK_W-1:0]   block_index
);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [CTR_W-1:0]   ctr_q;
  logic [BLK_W-1:0]   blk_q, nb_q;
  logic               use_key_q, use_nonce_q, use_ctr_q;
  logic               err_q;

  logic               acq_active, acq_stream;
  field_t             acq_field;
  logic               accept, last, timeout;
  logic [CHUNK_W-1:0] word;
  logic               start_ok, bad_nb, skip_key, last_blk, advance, err_set;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign bad_nb   = (num_blocks == '0) || (num_blocks > BLK_W'(MAX_BLOCKS));
  assign last_blk = (BLK_W'(blk_q + 1'b1) == nb_q);

`ifdef CHACHA_KEY_CACHE_EN
  logic key_loaded_q;
  assign skip_key = reuse_key & key_loaded_q;
`else
  assign skip_key = 1'b0;
`endif

  always_comb begin
    acq_active = 1'b0;
    acq_field  = FIELD_KEY;
    acq_stream = 1'b0;
    unique case (state_q)
      ST_ACQ_KEY: begin
        acq_active = 1'b1;
        acq_field  = FIELD_KEY;
        acq_stream = use_key_q;
      end
      ST_ACQ_NONCE: begin
        acq_active = 1'b1;
        acq_field  = FIELD_NONCE;
        acq_stream = use_nonce_q;
      end
      ST_ACQ_CTR: begin
        acq_active = 1'b1;
        acq_field  = FIELD_CTR;
        acq_stream = use_ctr_q;
      end
      default: ;
    endcase
  end

  chacha_field_assembler #(
    .CHUNK_W (CHUNK_W),
    .TIMEOUT (TIMEOUT)
  ) u_assembler (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (acq_active),
    .use_stream    (acq_stream),
    .field         (acq_field),
    .chunk_valid   (chunk_valid),
    .chunk_type    (chunk_type),
    .chunk         (chunk),
    .trng_ready    (trng_ready),
    .trng_data     (trng_data),
    .chunk_request (chunk_request),
    .trng_request  (trng_request),
    .request_type  (request_type),
    .chunk_index   (chunk_index),
    .accept        (accept),
    .last          (last),
    .timeout       (timeout),
    .word          (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bad_nb)        state_d = ST_FINISH;
          else if (skip_key) state_d = ST_ACQ_NONCE;
          else               state_d = ST_ACQ_KEY;
        end
      end
      ST_ACQ_KEY: begin
        if (timeout) begin
          state_d = ST_FINISH;
          err_set = 1'b1;
        end else if (last) begin
          state_d = ST_ACQ_NONCE;
        end
      end
      ST_ACQ_NONCE: begin
        if (timeout) begin
          state_d = ST_FINISH;
          err_set = 1'b1;
        end else if (last) begin
          state_d = ST_ACQ_CTR;
        end
      end
      ST_ACQ_CTR: begin
        if (timeout) begin
          state_d = ST_FINISH;
          err_set = 1'b1;
        end else if (last) begin
          state_d = ST_CORE_GO;
        end
      end
      ST_CORE_GO: state_d = ST_CORE_WAIT;
      ST_CORE_WAIT: begin
        // The counter never wraps: an exhausted counter ends the session with an error.
        if (core_done) begin
          if (last_blk) begin
            state_d = ST_FINISH;
          end else if (ctr_q == '1) begin
            state_d = ST_FINISH;
            err_set = 1'b1;
          end else begin
            state_d = ST_CORE_GO;
            advance = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      blk_q       <= '0;
      nb_q        <= '0;
      use_key_q   <= 1'b0;
      use_nonce_q <= 1'b0;
      use_ctr_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        nb_q        <= num_blocks;
        use_key_q   <= use_streamed_key;
        use_nonce_q <= use_streamed_nonce;
        use_ctr_q   <= use_streamed_counter;
        blk_q       <= '0;
        err_q       <= bad_nb;
`ifndef CHACHA_KEY_CACHE_EN
        key_q       <= '0;
`endif
      end
      // Each accepted word goes straight into its slot, including the final one.
      if (accept) begin
        unique case (acq_field)
          FIELD_KEY:   key_q[int'(chunk_index) * CHUNK_W +: CHUNK_W]   <= word;
          FIELD_NONCE: nonce_q[int'(chunk_index) * CHUNK_W +: CHUNK_W] <= word;
          default:     ctr_q[int'(chunk_index) * CHUNK_W +: CHUNK_W]   <= word;
        endcase
      end
      if (advance) begin
        ctr_q <= ctr_q + 1'b1;
        blk_q <= blk_q + 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef CHACHA_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  key_loaded_q <= 1'b0;
    else if (last && (acq_field == FIELD_KEY))   key_loaded_q <= 1'b1;
  end
`endif

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH);
  assign error        = err_q;
  assign core_start   = (state_q == ST_CORE_GO);
  assign block_valid  = (state_q == ST_CORE_WAIT) && core_done;
  assign block_index  = blk_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_counter = ctr_q;

endmodule

// File: tb/tb_chacha_multiblock_ctrl.sv
// Directed self-checking bench for chacha_multiblock_ctrl (CHUNK_W=8, TIMEOUT=16,
// default build without CHACHA_KEY_CACHE_EN).
module tb_chacha_multiblock_ctrl;

  localparam int CHUNK_W    = 8;
  localparam int MAX_BLOCKS = 16;
  localparam int TIMEOUT    = 16;
  localparam int BLK_W      = 5;

  localparam logic [255:0] KEY_SEQ =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [95:0]  NONCE_C = 96'ha1a2a3a4_b1b2b3b4_c1c2c3c4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [BLK_W-1:0]   num_blocks;
  logic               use_streamed_key, use_streamed_nonce, use_streamed_counter;
  logic               busy, done, error;
  logic               chunk_request;
  logic [1:0]         request_type;
  logic [4:0]         chunk_index;
  logic               chunk_valid;
  logic [1:0]         chunk_type;
  logic [CHUNK_W-1:0] chunk;
  logic               trng_request, trng_ready;
  logic [31:0]        trng_data;
  logic               core_start, core_done;
  logic [255:0]       core_key;
  logic [95:0]        core_nonce;
  logic [31:0]        core_counter;
  logic               block_valid;
  logic [BLK_W-1:0]   block_index;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int bv_cnt = 0;

  chacha_multiblock_ctrl #(
    .CHUNK_W    (CHUNK_W),
    .MAX_BLOCKS (MAX_BLOCKS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .num_blocks           (num_blocks),
    .use_streamed_key     (use_streamed_key),
    .use_streamed_nonce   (use_streamed_nonce),
    .use_streamed_counter (use_streamed_counter),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .chunk_request        (chunk_request),
    .request_type         (request_type),
    .chunk_index          (chunk_index),
    .chunk_valid          (chunk_valid),
    .chunk_type           (chunk_type),
    .chunk                (chunk),
    .trng_request         (trng_request),
    .trng_ready           (trng_ready),
    .trng_data            (trng_data),
    .core_start           (core_start),
    .core_done            (core_done),
    .core_key             (core_key),
    .core_nonce           (core_nonce),
    .core_counter         (core_counter),
    .block_valid          (block_valid),
    .block_index          (block_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_start)  start_cnt++;
    if (block_valid) bv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [BLK_W-1:0] nb, input logic uk, input logic un,
                               input logic uc);
    num_blocks           = nb;
    use_streamed_key     = uk;
    use_streamed_nonce   = un;
    use_streamed_counter = uc;
    start                = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One word per cycle; TRNG words carry junk in the upper bits that must be ignored.
  task automatic feed_field(input logic stream, input logic [1:0] ftype, input int nwords,
                            input logic [255:0] val);
    for (int i = 0; i < nwords; i++) begin
      if (stream) begin
        chunk_valid = 1'b1;
        chunk_type  = ftype;
        chunk       = val[i*8 +: 8];
      end else begin
        trng_ready  = 1'b1;
        trng_data   = {24'ha5a5a5, val[i*8 +: 8]};
      end
      tick();
    end
    chunk_valid = 1'b0;
    trng_ready  = 1'b0;
  endtask

  task automatic acquire(input logic uk, input logic un, input logic uc,
                         input logic [255:0] key, input logic [95:0] nonce,
                         input logic [31:0] ctr);
    feed_field(uk, 2'd0, 32, key);
    feed_field(un, 2'd1, 12, {160'b0, nonce});
    feed_field(uc, 2'd2, 4, {224'b0, ctr});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_blocks = '0;
    use_streamed_key = 1'b0; use_streamed_nonce = 1'b0; use_streamed_counter = 1'b0;
    chunk_valid = 1'b0; chunk_type = 2'd0; chunk = '0;
    trng_ready = 1'b0; trng_data = '0; core_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, error, chunk_request, trng_request, core_start, block_valid} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, error, chunk_request, trng_request, core_start, block_valid});
    end
    checks++;
    if ({core_key, core_nonce, core_counter, block_index, chunk_index} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: key %h ctr %h expected all zero", core_key, core_counter);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_trng_single();
    int s0, b0;
    s0 = start_cnt; b0 = bv_cnt;
    start_session(5'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({busy, trng_request, chunk_request} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL trng_req: got %b expected 110", {busy, trng_request, chunk_request});
    end
    acquire(1'b0, 1'b0, 1'b0, KEY_SEQ, NONCE_C, 32'h11223344);
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trng_core_start: got %b expected 1", core_start);
    end
    checks++;
    if (core_key !== KEY_SEQ) begin
      errors++;
      $display("[TB] FAIL trng_key: got %h expected %h", core_key, KEY_SEQ);
    end
    checks++;
    if (core_nonce !== NONCE_C || core_counter !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL trng_nonce_ctr: got %h/%h expected %h/11223344",
               core_nonce, core_counter, NONCE_C);
    end
    repeat (3) tick();
    core_done = 1'b1;
    #1;
    checks++;
    if (block_valid !== 1'b1 || block_index !== 5'd0) begin
      errors++;
      $display("[TB] FAIL trng_block_valid: got %b/%0d expected 1/0", block_valid, block_index);
    end
    tick();
    core_done = 1'b0;
    checks++;
    if ({done, error, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL trng_done: got %b expected 101", {done, error, busy});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00 || start_cnt - s0 != 1 || bv_cnt - b0 != 1) begin
      errors++;
      $display("[TB] FAIL trng_end: done/busy %b starts %0d valids %0d expected 00 1 1",
               {done, busy}, start_cnt - s0, bv_cnt - b0);
    end
  endtask

  task automatic test_stream_multi();
    int s0, b0;
    s0 = start_cnt; b0 = bv_cnt;
    start_session(5'd4, 1'b1, 1'b1, 1'b1);
    chunk_valid = 1'b1; chunk_type = 2'd1; chunk = 8'hee;
    repeat (3) tick();
    chunk_valid = 1'b0;
    checks++;
    if (chunk_index !== 5'd0 || request_type !== 2'd0 || chunk_request !== 1'b1) begin
      errors++;
      $display("[TB] FAIL type_mismatch: idx %0d type %0d req %b expected 0 0 1",
               chunk_index, request_type, chunk_request);
    end
    acquire(1'b1, 1'b1, 1'b1, KEY_SEQ, NONCE_C, 32'd5);
    checks++;
    if (core_key !== KEY_SEQ || core_nonce !== NONCE_C) begin
      errors++;
      $display("[TB] FAIL stream_key: got %h expected %h", core_key, KEY_SEQ);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (core_start !== 1'b1 || core_counter !== 32'(5 + b)) begin
        errors++;
        $display("[TB] FAIL multi_counter[%0d]: start %b ctr %0d expected 1 %0d",
                 b, core_start, core_counter, 5 + b);
      end
      core_done = (b == 1);
      #1;
      if (b == 1) begin
        checks++;
        if (block_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL early_core_done: block_valid %b expected 0", block_valid);
        end
      end
      tick();
      core_done = 1'b1;
      #1;
      checks++;
      if (block_valid !== 1'b1 || block_index !== 5'(b)) begin
        errors++;
        $display("[TB] FAIL multi_index[%0d]: valid %b index %0d expected 1 %0d",
                 b, block_valid, block_index, b);
      end
      tick();
      core_done = 1'b0;
    end
    checks++;
    if ({done, error} !== 2'b10 || start_cnt - s0 != 4 || bv_cnt - b0 != 4) begin
      errors++;
      $display("[TB] FAIL multi_end: done/err %b starts %0d valids %0d expected 10 4 4",
               {done, error}, start_cnt - s0, bv_cnt - b0);
    end
    tick();
  endtask

  task automatic test_overflow();
    int s0;
    s0 = start_cnt;
    start_session(5'd3, 1'b0, 1'b0, 1'b1);
    acquire(1'b0, 1'b0, 1'b1, KEY_SEQ, NONCE_C, 32'hfffffffe);
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (core_start !== 1'b1 || core_counter !== 32'hfffffffe + 32'(b)) begin
        errors++;
        $display("[TB] FAIL ovf_counter[%0d]: start %b ctr %h", b, core_start, core_counter);
      end
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
    end
    checks++;
    if ({done, error, core_start} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL ovf_done: got %b expected 110", {done, error, core_start});
    end
    tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || start_cnt - s0 != 2) begin
      errors++;
      $display("[TB] FAIL ovf_hold: err %b busy %b starts %0d expected 1 0 2",
               error, busy, start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int s0, k;
    s0 = start_cnt;
    start_session(5'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_cleared_at_start: got %b expected 0", error);
    end
    feed_field(1'b1, 2'd0, 4, KEY_SEQ);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        k = c;
        break;
      end
    end
    checks++;
    if (k != 16 || error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout: done after %0d cycles err %b expected 16 1", k, error);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || start_cnt - s0 != 0 || core_key[31:0] !== 32'h03020100) begin
      errors++;
      $display("[TB] FAIL timeout_end: busy %b starts %0d key_lo %h expected 0 0 03020100",
               busy, start_cnt - s0, core_key[31:0]);
    end
  endtask

  task automatic test_bad_blocks();
    int s0;
    s0 = start_cnt;
    start_session(5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({done, error, busy} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL nb_zero: got %b expected 111", {done, error, busy});
    end
    tick();
    start_session(5'd17, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({done, error} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL nb_over: got %b expected 11", {done, error});
    end
    repeat (2) tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || start_cnt - s0 != 0) begin
      errors++;
      $display("[TB] FAIL nb_hold: err %b busy %b starts %0d expected 1 0 0",
               error, busy, start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    start_session(5'd2, 1'b0, 1'b0, 1'b0);
    feed_field(1'b0, 2'd0, 5, KEY_SEQ);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, trng_request} !== 3'b000 || core_key !== '0 || chunk_index !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: ctrl %b key %h idx %0d expected 000 0 0",
               {busy, done, trng_request}, core_key, chunk_index);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_trng_single();
    test_stream_multi();
    test_overflow();
    test_timeout();
    test_bad_blocks();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
